program_counter_unit: RTL and testbench

PROGRAM_COUNTER_UNIT -- requirements
Module: program_counter_unit

---
 rtl/program_counter_unit.sv | 131 +++++++++++++
 tb/tb_program_counter_unit.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/program_counter_unit.sv
// Program counter and fetch-request generator with trap/mret/redirect/halt control.
// Latency: fetch_addr is registered (next PC visible one cycle after the cause); fetch_valid follows stall combinationally.
// Backpressure: fetch_valid && !fetch_ready holds the PC, so fetch_addr stays stable until accepted or redirected.
//
// Ports:
//   clk, reset                      - rising-edge clock, asynchronous active-high reset
//   stall                           - hold PC and suppress the fetch request
//   fetch_valid/fetch_ready         - fetch request handshake, fetch_addr is the current PC
//   redirect_valid/redirect_target  - branch or jump redirect
//   trap_req                        - load TRAP_VECTOR
//   mret_req/mepc                   - trap return to mepc (low bits cleared)
//   halt_req/resume/halted          - debug-style halt control and status
//   misalign_exc/bad_addr           - one-cycle pulse and captured target of a misaligned redirect
//   fetch_count                     - number of accepted fetches (wraps)
module program_counter_unit #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(32'h0000_0000),
    parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h0000_0100),
    parameter int              IALIGN       = 4,
    parameter int              CNT_W        = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    output logic             fetch_valid,
    input  logic             fetch_ready,
    output logic [XLEN-1:0]  fetch_addr,
    input  logic             redirect_valid,
    input  logic [XLEN-1:0]  redirect_target,
    input  logic             trap_req,
    input  logic             mret_req,
    input  logic [XLEN-1:0]  mepc,
    input  logic             halt_req,
    input  logic             resume,
    output logic             halted,
    output logic             misalign_exc,
    output logic [XLEN-1:0]  bad_addr,
    output logic [CNT_W-1:0] fetch_count
);

    // Low address bits that must be zero for a legal instruction address.
    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(IALIGN - 1);
    localparam logic [XLEN-1:0] PC_STEP    = XLEN'(IALIGN);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic            boot_armed;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_nxt;
    logic            accept;
    logic            misaligned;
    logic            misalign_take;

    assign fetch_valid = (state == RUN) && !stall;
    assign accept      = fetch_valid && fetch_ready;
    assign fetch_addr  = pc;
    assign halted      = (state == HALT);
    assign misaligned  = |(redirect_target & ALIGN_MASK);

    // State register. The first edge after reset release only arms BOOT, so
    // the edge that may sit close to the release is never a fetch cycle; the
    // request appears after the second edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= BOOT;
            boot_armed <= 1'b0;
        end else begin
            state      <= state_nxt;
            boot_armed <= 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            BOOT:    if (boot_armed) state_nxt = RUN;
            RUN:     if (halt_req)   state_nxt = HALT;
            // resume wins over a simultaneous halt_req
            HALT:    if (resume)     state_nxt = RUN;
            default: state_nxt = BOOT;
        endcase
    end

    // Next-PC select: trap > mret > redirect > accept > hold. Control-flow
    // loads apply in every state and never touch the FSM.
    always_comb begin
        pc_nxt        = pc;
        misalign_take = 1'b0;
        if (trap_req) begin
            pc_nxt = TRAP_VECTOR;
        end else if (mret_req) begin
            pc_nxt = mepc & ~ALIGN_MASK;
        end else if (redirect_valid) begin
            if (misaligned) begin
                pc_nxt        = TRAP_VECTOR;
                misalign_take = 1'b1;
            end else begin
                pc_nxt = redirect_target;
            end
        end else if (accept) begin
            pc_nxt = pc + PC_STEP;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc           <= RESET_VECTOR;
            misalign_exc <= 1'b0;
            bad_addr     <= '0;
            fetch_count  <= '0;
        end else begin
            pc           <= pc_nxt;
            misalign_exc <= misalign_take;
            if (misalign_take) begin
                bad_addr <= redirect_target;
            end
            // Every accepted request is counted, even if a redirect overrides
            // the sequential PC in the same cycle.
            if (accept) begin
                fetch_count <= fetch_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_program_counter_unit.sv
module tb_program_counter_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        fetch_ready;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        trap_req;
    logic        mret_req;
    logic [31:0] mepc;
    logic        halt_req;
    logic        resume;
    logic        fetch_valid;
    logic [31:0] fetch_addr;
    logic        halted;
    logic        misalign_exc;
    logic [31:0] bad_addr;
    logic [31:0] fetch_count;

    // Second instance: 2-byte alignment and a 3-bit fetch counter.
    logic        ready1;
    logic        r1_valid;
    logic [31:0] r1_target;
    logic        fv1;
    logic [31:0] addr1;
    logic        halted1;
    logic        mis1;
    logic [31:0] bad1;
    logic [2:0]  cnt1;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    program_counter_unit dut (
        .clk             (clk),
        .reset           (reset),
        .stall           (stall),
        .fetch_valid     (fetch_valid),
        .fetch_ready     (fetch_ready),
        .fetch_addr      (fetch_addr),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .trap_req        (trap_req),
        .mret_req        (mret_req),
        .mepc            (mepc),
        .halt_req        (halt_req),
        .resume          (resume),
        .halted          (halted),
        .misalign_exc    (misalign_exc),
        .bad_addr        (bad_addr),
        .fetch_count     (fetch_count)
    );

    program_counter_unit #(.IALIGN(2), .CNT_W(3)) dut1 (
        .clk             (clk),
        .reset           (reset),
        .stall           (1'b0),
        .fetch_valid     (fv1),
        .fetch_ready     (ready1),
        .fetch_addr      (addr1),
        .redirect_valid  (r1_valid),
        .redirect_target (r1_target),
        .trap_req        (1'b0),
        .mret_req        (1'b0),
        .mepc            (32'h0),
        .halt_req        (1'b0),
        .resume          (1'b0),
        .halted          (halted1),
        .misalign_exc    (mis1),
        .bad_addr        (bad1),
        .fetch_count     (cnt1)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0; stall = 1'b0; fetch_ready = 1'b0;
        redirect_valid = 1'b0; redirect_target = 32'h0;
        trap_req = 1'b0; mret_req = 1'b0; mepc = 32'h0;
        halt_req = 1'b0; resume = 1'b0;
        ready1 = 1'b0; r1_valid = 1'b0; r1_target = 32'h0;

        // Asynchronous reset before any clock edge
        #1 reset = 1'b1;
        #1;
        chk("rst_fv",    fetch_valid,  0);
        chk("rst_addr",  fetch_addr,   32'h0);
        chk("rst_halt",  halted,       0);
        chk("rst_mis",   misalign_exc, 0);
        chk("rst_bad",   bad_addr,     32'h0);
        chk("rst_cnt",   fetch_count,  32'h0);

        // Release with fetch_ready held high
        step(); step();
        reset = 1'b0; fetch_ready = 1'b1;
        step();
        chk("boot_fv", fetch_valid, 0);
        step();
        chk("run_fv",    fetch_valid, 1);
        chk("seq_addr0", fetch_addr,  32'h0);
        step();
        chk("seq_addr4", fetch_addr,  32'h4);
        chk("seq_cnt1",  fetch_count, 32'd1);
        step();
        chk("seq_addr8", fetch_addr,  32'h8);
        step();
        chk("seq_addrc", fetch_addr,  32'hC);
        chk("seq_cnt3",  fetch_count, 32'd3);

        // Back to 0x8, then hold with fetch_ready low
        redirect_valid = 1'b1; redirect_target = 32'h8; fetch_ready = 1'b0;
        step();
        redirect_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bp_addr", fetch_addr,  32'h8);
            chk("bp_fv",   fetch_valid, 1);
        end
        chk("bp_cnt", fetch_count, 32'd3);

        // Stall suppresses the request and holds the PC
        stall = 1'b1; fetch_ready = 1'b1;
        #1;
        chk("stall_fv", fetch_valid, 0);
        step();
        chk("stall_addr", fetch_addr,  32'h8);
        chk("stall_cnt",  fetch_count, 32'd3);
        stall = 1'b0; fetch_ready = 1'b0;

        // Trap beats an aligned redirect
        redirect_valid = 1'b1; redirect_target = 32'h200; trap_req = 1'b1;
        step();
        chk("trap_addr", fetch_addr,   32'h100);
        chk("trap_mis",  misalign_exc, 0);
        trap_req = 1'b0; redirect_target = 32'h202;
        step();
        chk("mis_addr",  fetch_addr,   32'h100);
        chk("mis_pulse", misalign_exc, 1);
        chk("mis_bad",   bad_addr,     32'h202);
        redirect_valid = 1'b0;
        step();
        chk("mis_end",  misalign_exc, 0);
        chk("mis_hold", bad_addr,     32'h202);
        // Misaligned redirect ignored under a trap
        redirect_valid = 1'b1; redirect_target = 32'h206; trap_req = 1'b1;
        step();
        redirect_valid = 1'b0; trap_req = 1'b0;
        chk("ign_mis", misalign_exc, 0);
        chk("ign_bad", bad_addr,     32'h202);

        // mret clears low bits
        mret_req = 1'b1; mepc = 32'h1237;
        step();
        mret_req = 1'b0;
        chk("mret_addr", fetch_addr, 32'h1234);

        // PC wrap at the top of the address space
        redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFFC;
        step();
        redirect_valid = 1'b0; fetch_ready = 1'b1;
        chk("top_addr", fetch_addr, 32'hFFFF_FFFC);
        step();
        chk("wrap_addr", fetch_addr,  32'h0);
        chk("wrap_cnt",  fetch_count, 32'd4);

        // Halt during an accept: the fetch still counts
        halt_req = 1'b1;
        step();
        halt_req = 1'b0;
        chk("halt_cnt",  fetch_count, 32'd5);
        chk("halt_addr", fetch_addr,  32'h4);
        chk("halt_flag", halted,      1);
        chk("halt_fv",   fetch_valid, 0);
        redirect_valid = 1'b1; redirect_target = 32'h40;
        step();
        redirect_valid = 1'b0;
        chk("hredir_addr", fetch_addr,  32'h40);
        chk("hredir_flag", halted,      1);
        chk("hredir_cnt",  fetch_count, 32'd5);
        // resume wins over halt_req
        resume = 1'b1; halt_req = 1'b1; fetch_ready = 1'b0;
        step();
        resume = 1'b0; halt_req = 1'b0;
        chk("res_flag", halted,      0);
        chk("res_fv",   fetch_valid, 1);
        chk("res_addr", fetch_addr,  32'h40);
        resume = 1'b1;
        step();
        resume = 1'b0;
        chk("res_run", halted, 0);

        // Asynchronous reset mid-handshake
        fetch_ready = 1'b1;
        #3 reset = 1'b1;
        #1;
        chk("arst_fv",   fetch_valid,  0);
        chk("arst_addr", fetch_addr,   32'h0);
        chk("arst_cnt",  fetch_count,  32'h0);
        chk("arst_halt", halted,       0);
        chk("arst_mis",  misalign_exc, 0);
        chk("arst_bad",  bad_addr,     32'h0);
        #1 reset = 1'b0;
        step();
        chk("rel_fv",  fetch_valid, 0);
        chk("rel_cnt", fetch_count, 32'h0);
        step();
        chk("rel_run",  fetch_valid, 1);
        chk("rel_addr", fetch_addr,  32'h0);
        step();
        chk("rel_addr4", fetch_addr,  32'h4);
        chk("rel_cnt1",  fetch_count, 32'd1);
        fetch_ready = 1'b0;

        // IALIGN=2 instance: 0x202 is legal, counter wraps at 7
        r1_valid = 1'b1; r1_target = 32'h202;
        step();
        r1_valid = 1'b0;
        chk("a2_addr", addr1, 32'h202);
        chk("a2_mis",  mis1,  0);
        chk("a2_bad",  bad1,  32'h0);
        ready1 = 1'b1;
        for (int i = 0; i < 7; i++) step();
        chk("a2_addr7", addr1, 32'h210);
        chk("a2_cnt7",  cnt1,  3'd7);
        step();
        chk("a2_wrap",  cnt1,  3'd0);
        chk("a2_addr8", addr1, 32'h212);
        ready1 = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
